// File: rtl/mem_arb_pkg.sv
// Shared encodings for the RAM port arbiter: FSM states, grant codes and owner selection.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_t;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_CPU  = 2'b01;
  localparam logic [1:0] GRANT_DMA  = 2'b10;

  // A lone requester wins. On a tie, the master that did not win last time wins.
  function automatic logic [1:0] pick_owner(input logic cpu_any,
                                            input logic dma_any,
                                            input logic [1:0] last_grant);
    logic [1:0] owner;
    owner = GRANT_NONE;
    if (cpu_any && dma_any)
      owner = (last_grant == GRANT_CPU) ? GRANT_DMA : GRANT_CPU;
    else if (cpu_any)
      owner = GRANT_CPU;
    else if (dma_any)
      owner = GRANT_DMA;
    return owner;
  endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous RAM port between the CPU (read/write) and a read-only DMA master,
// sequencing each access as issue, fixed-latency wait and a one-cycle response pulse.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | sample requests, arbitrate, latch owner/address/data
// ST_ISSUE | drive ram_en (and ram_we for CPU writes) for one cycle
// ST_WAIT  | count down remaining RAM latency (skipped when RAM_LAT==1)
// ST_RESP  | owner's ready/ack pulse, read data passed through and captured
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 32,
  parameter int RAM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req_r,
  input  logic              cpu_req_w,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  input  logic              dma_req,
  input  logic [ADDR_W-1:0] dma_addr,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_ack,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [1:0]        grant
);

  localparam logic [1:0] WAIT_LOAD = 2'(RAM_LAT - 1);

  arb_state_t        state;
  arb_state_t        state_nxt;
  logic [1:0]        owner;
  logic [1:0]        last_grant;
  logic [1:0]        pick;
  logic              cpu_any;
  logic              we_q;
  logic [1:0]        wait_cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic [DATA_W-1:0] dma_rdata_q;

  assign cpu_any = cpu_req_r | cpu_req_w;
  assign pick    = pick_owner(cpu_any, dma_req, last_grant);

  always_ff @(posedge clk) begin
    if (reset)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (pick != GRANT_NONE) state_nxt = ST_ISSUE;
      ST_ISSUE: state_nxt = (RAM_LAT == 1) ? ST_RESP : ST_WAIT;
      ST_WAIT:  if (wait_cnt <= 2'd1) state_nxt = ST_RESP;
      ST_RESP:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    cpu_ready = 1'b0;
    dma_ack   = 1'b0;
    grant     = GRANT_NONE;
    cpu_rdata = cpu_rdata_q;
    dma_rdata = dma_rdata_q;
    if (state != ST_IDLE)
      grant = owner;
    if (state == ST_ISSUE) begin
      ram_en = 1'b1;
      ram_we = we_q;
    end
    if (state == ST_RESP) begin
      cpu_ready = (owner == GRANT_CPU);
      dma_ack   = (owner == GRANT_DMA);
      if (owner == GRANT_CPU && !we_q)
        cpu_rdata = ram_rdata;
      if (owner == GRANT_DMA)
        dma_rdata = ram_rdata;
    end
  end

  // Access latches; a write request wins over a simultaneous CPU read request.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner       <= GRANT_NONE;
      last_grant  <= GRANT_DMA;
      we_q        <= 1'b0;
      wait_cnt    <= 2'd0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick != GRANT_NONE) begin
            owner      <= pick;
            last_grant <= pick;
            we_q       <= (pick == GRANT_CPU) && cpu_req_w;
            addr_q     <= (pick == GRANT_CPU) ? cpu_addr : dma_addr;
            wdata_q    <= cpu_wdata;
          end
        end
        ST_ISSUE: wait_cnt <= WAIT_LOAD;
        ST_WAIT:  wait_cnt <= wait_cnt - 2'd1;
        ST_RESP: begin
          if (owner == GRANT_CPU && !we_q)
            cpu_rdata_q <= ram_rdata;
          if (owner == GRANT_DMA)
            dma_rdata_q <= ram_rdata;
        end
        default: ;
      endcase
    end
  end

  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;

endmodule
